// File: rtl/ram_responder.sv
// ram_responder: behavioural single-port RAM slave with a fixed BUSY latency.
// Answers ramREN/ramWEN requests with a FREE/BUSY/ACCESS/ERROR handshake.
module ram_responder #(
  parameter int unsigned LAT       = 2,
  parameter int unsigned ADDR_BITS = 14
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam int unsigned CW    = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [CW-1:0] CNT_LOAD = (LAT == 0) ? '0 : CW'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   op_q, op_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            mem [DEPTH];

  logic                   req_c;
  logic                   illegal_c;
  logic                   mem_we_c;
  logic [ADDR_BITS-1:0]   word_idx_c;

  assign req_c      = ramREN | ramWEN;
  assign word_idx_c = ramaddr[ADDR_BITS+1:2];
  assign illegal_c  = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00)
                    | (req_c & (|ramaddr[31:ADDR_BITS+2]));
  assign mem_we_c   = (state_q == S_ACC) & op_q & ~illegal_c;

  // State register with latched transaction fields
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; ACC re-enters through the same start rule as IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    if (illegal_c) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_ACC: begin
          if (req_c) begin
            op_d   = ramWEN;
            addr_d = word_idx_c;
            if (LAT == 0) begin
              state_d = S_ACC;
              cnt_d   = '0;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_LOAD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (!req_c) begin
            state_d = S_IDLE;
          end else if ((ramWEN != op_q) || (word_idx_c != addr_q)) begin
            op_d   = ramWEN;
            addr_d = word_idx_c;
            cnt_d  = CNT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = S_ACC;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs; an illegal request shows ERROR immediately
  always_comb begin
    ramstate = FREE;
    ramload  = '0;
    case (state_q)
      S_WAIT:  ramstate = BUSY;
      S_ACC: begin
        ramstate = ACCESS;
        ramload  = mem[addr_q];
      end
      default: ramstate = FREE;
    endcase
    if (illegal_c) ramstate = ERROR;
  end

  // Write lands on the edge that closes ACC; ramstore is taken live
  always_ff @(posedge CLK) begin
    if (mem_we_c) mem[addr_q] <= ramstore;
  end

endmodule

// File: tb/tb_ram_responder.sv
// Randomized self-checking bench for ram_responder: LAT=2 instance for latency,
// restart, error and abort cases; LAT=0 instance for back-to-back reads.
module tb_ram_responder;

  localparam int unsigned AB    = 14;
  localparam int unsigned LAT_A = 2;
  localparam int unsigned DEPTH = 1 << AB;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        a_ren, a_wen, b_ren, b_wen;
  logic [31:0] a_addr, a_store, a_load, b_addr, b_store, b_load;
  logic [1:0]  a_state, b_state;

  logic [31:0] model_a [DEPTH];
  logic [31:0] model_b [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_responder #(.LAT(LAT_A), .ADDR_BITS(AB)) u_a (
    .CLK(clk), .nRST(nrst), .ramREN(a_ren), .ramWEN(a_wen),
    .ramaddr(a_addr), .ramstore(a_store), .ramload(a_load), .ramstate(a_state)
  );

  ram_responder #(.LAT(0), .ADDR_BITS(AB)) u_b (
    .CLK(clk), .nRST(nrst), .ramREN(b_ren), .ramWEN(b_wen),
    .ramaddr(b_addr), .ramstore(b_store), .ramload(b_load), .ramstate(b_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on A starting from FREE; request dropped inside ACCESS
  task automatic a_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] exp_load;
    exp_load = model_a[addr[AB+1:2]];
    a_ren   = ~wr;
    a_wen   = wr;
    a_addr  = addr;
    a_store = data;
    for (int c = 0; c <= int'(LAT_A) + 1; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("a_start_free", 32'(a_state), 32'(FREE));
      else if (c <= int'(LAT_A)) check_eq("a_busy", 32'(a_state), 32'(BUSY));
      else begin
        check_eq("a_access", 32'(a_state), 32'(ACCESS));
        if (!wr) check_eq("a_rdata", a_load, exp_load);
        a_ren = 1'b0;
        a_wen = 1'b0;
      end
      if (c <= int'(LAT_A)) check_eq("a_load_zero", a_load, 32'h0);
      next_cycle();
    end
    if (wr) model_a[addr[AB+1:2]] = data;
  endtask

  // Illegal request held across one edge, then dropped; expect ERROR then FREE
  task automatic a_err(input logic ren, input logic wen, input logic [31:0] addr);
    a_ren   = ren;
    a_wen   = wen;
    a_addr  = addr;
    a_store = 32'hBAD0_BAD0;
    @(negedge clk);
    check_eq("a_err_state", 32'(a_state), 32'(ERROR));
    next_cycle();
    a_ren  = 1'b0;
    a_wen  = 1'b0;
    a_addr = 32'h0;
    @(negedge clk);
    check_eq("a_err_recover", 32'(a_state), 32'(FREE));
    next_cycle();
  endtask

  initial begin
    logic [AB-1:0] idx, prev_idx;
    logic          wr;

    for (int i = 0; i < int'(DEPTH); i++) begin
      model_a[i]  = $urandom;
      model_b[i]  = $urandom;
      u_a.mem[i]  = model_a[i];
      u_b.mem[i]  = model_b[i];
    end

    nrst = 1'b0;
    a_ren = 1'b0; a_wen = 1'b0; a_addr = 32'h0; a_store = 32'h0;
    b_ren = 1'b0; b_wen = 1'b0; b_addr = 32'h0; b_store = 32'h0;

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_state", 32'(a_state), 32'(FREE));
      check_eq("rst_load", a_load, 32'h0);
      check_eq("rst_state_b", 32'(b_state), 32'(FREE));
    end
    next_cycle();
    nrst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("idle_state", 32'(a_state), 32'(FREE));
      check_eq("idle_load", a_load, 32'h0);
      next_cycle();
    end

    // Write then read back
    a_txn(1'b1, 32'h40, 32'hDEAD_BEEF);
    a_txn(1'b0, 32'h40, 32'h0);

    // Restart: switch from 0x100 to 0x200 during the first BUSY cycle
    a_ren = 1'b1; a_wen = 1'b0; a_addr = 32'h100;
    @(negedge clk);
    check_eq("rs_free", 32'(a_state), 32'(FREE));
    next_cycle();
    @(negedge clk);
    check_eq("rs_busy1", 32'(a_state), 32'(BUSY));
    a_addr = 32'h200;
    next_cycle();
    for (int c = 0; c < int'(LAT_A); c++) begin
      @(negedge clk);
      check_eq("rs_busy_after", 32'(a_state), 32'(BUSY));
      next_cycle();
    end
    @(negedge clk);
    check_eq("rs_access", 32'(a_state), 32'(ACCESS));
    check_eq("rs_rdata", a_load, model_a[32'h200 >> 2]);
    a_ren = 1'b0;
    next_cycle();
    a_txn(1'b0, 32'h100, 32'h0);

    // Illegal requests leave memory untouched
    a_err(1'b1, 1'b1, 32'h40);
    a_txn(1'b0, 32'h40, 32'h0);
    a_err(1'b1, 1'b0, 32'h3);
    a_err(1'b0, 1'b1, 32'h0001_0000);
    a_txn(1'b1, 32'h0000_FFFC, 32'hCAFE_F00D);
    a_txn(1'b0, 32'h0000_FFFC, 32'h0);

    // Illegal address mid-WAIT aborts the read
    a_ren = 1'b1; a_addr = 32'h44;
    next_cycle();
    a_addr = 32'h47;
    #1;
    check_eq("mid_err", 32'(a_state), 32'(ERROR));
    next_cycle();
    a_ren = 1'b0; a_addr = 32'h44;
    @(negedge clk);
    check_eq("mid_err_free", 32'(a_state), 32'(FREE));
    next_cycle();

    // Reset during the ACCESS cycle of a write suppresses it
    a_wen = 1'b1; a_addr = 32'h80; a_store = 32'h1234_5678;
    repeat (LAT_A + 1) next_cycle();
    @(negedge clk);
    check_eq("abort_access", 32'(a_state), 32'(ACCESS));
    nrst = 1'b0;
    #1;
    check_eq("abort_free", 32'(a_state), 32'(FREE));
    a_wen = 1'b0;
    next_cycle();
    @(negedge clk);
    nrst = 1'b1;
    next_cycle();
    a_txn(1'b0, 32'h80, 32'h0);

    // Randomized transactions with idle gaps
    for (int n = 0; n < 40; n++) begin
      wr  = 1'($urandom_range(0, 1));
      idx = ($urandom_range(0, 7) == 0) ? AB'(DEPTH - 1) : AB'($urandom_range(0, 31));
      a_txn(wr, {16'h0, idx, 2'b00}, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_eq("gap_free", 32'(a_state), 32'(FREE));
        next_cycle();
      end
    end

    // LAT=0 back-to-back reads: ACCESS every cycle with the previous address's data
    prev_idx = '0;
    b_ren = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      idx    = (k < 3) ? AB'(k) : AB'($urandom_range(0, 255));
      b_addr = {16'h0, idx, 2'b00};
      @(negedge clk);
      if (k == 0) check_eq("b2b_first", 32'(b_state), 32'(FREE));
      else begin
        check_eq("b2b_access", 32'(b_state), 32'(ACCESS));
        check_eq("b2b_rdata", b_load, model_b[prev_idx]);
      end
      if (k == 20) b_ren = 1'b0;
      prev_idx = idx;
      next_cycle();
    end
    @(negedge clk);
    check_eq("b2b_end_free", 32'(b_state), 32'(FREE));
    check_eq("b2b_end_load", b_load, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Behavioural RAM slave that answers the single-port RAM request interface driven by the memory controller. It accepts word reads (`ramREN`) and writes (`ramWEN`) and models a fixed access latency through a `BUSY` wait phase. It reports completion with a one-cycle `ACCESS` state, which the controller uses to release `iwait`/`dwait`. It replaces the ideal RAM in the system testbench and in synthesis of the single-cycle and pipeline datapaths.

## Interface
- `LAT`, 2 — number of `BUSY` cycles before `ACCESS`; 0 is legal.
- `ADDR_BITS`, 14 — word-address width; the memory holds 2^ADDR_BITS 32-bit words.
- `CLK` in 1 — clock; all state changes on the rising edge.
- `nRST` in 1 — asynchronous, active-low reset.
- `ramREN` in 1 — read request; held until `ACCESS`.
- `ramWEN` in 1 — write request; held until `ACCESS`.
- `ramaddr` in 32 — byte address; bits [1:0] must be 0.
- `ramstore` in 32 — write data.
- `ramload` out 32 — read data; valid only while `ramstate == ACCESS` for a read.
- `ramstate` out `ramstate_t` (2) — `FREE`, `BUSY`, `ACCESS` or `ERROR` (from `cpu_types_pkg`).

## Operation
- **Request definitions**
  - Request = `ramREN | ramWEN`.
  - Illegal request = any one of:
    - `ramREN & ramWEN`;
    - `ramaddr[1:0] != 0`;
    - `ramaddr[31:ADDR_BITS+2] != 0` while request is high.
  - Word index = `ramaddr[ADDR_BITS+1:2]`.
- **State machine**: `IDLE`, `WAIT`, `ACC`. State output mapping: `IDLE`→`FREE`, `WAIT`→`BUSY`, `ACC`→`ACCESS`. An illegal request overrides the output with `ERROR` (combinational).
- **Latched fields**: `op` (read/write) and `addr` are latched whenever a transaction starts.
- **Down-counter `cnt`**: width `$clog2(LAT+1)`, minimum 1.
- **Transitions**
  - `IDLE`, legal request:
    - `LAT==0` → `ACC`;
    - otherwise → `WAIT` with `cnt=LAT-1`. Latch `op`/`addr` in either case.
  - `WAIT`:
    - request dropped → `IDLE`;
    - `op` or `ramaddr` differs from latch → restart: re-latch, `cnt=LAT-1`, stay in `WAIT`;
    - `cnt==0` → `ACC`;
    - else `cnt--`.
  - `ACC`: exactly one cycle.
    - legal request present → new transaction (same entry rule as `IDLE`), even if the address is unchanged;
    - otherwise → `IDLE`.
  - Illegal request in any state → next state `IDLE`, counter cleared, no memory update.
- **Read**: `ramload = mem[addr]` (combinational from the array) during `ACC`; 0 in all other states.
- **Write**: `mem[addr] <= ramstore` on the rising edge that ends the `ACC` cycle. `ramstore` is sampled live at that edge, not at request start.
- **Memory contents**: not cleared by reset, undefined until written. The testbench may preload through hierarchical access.

## Timing
- **Reset** (async, while `nRST=0`): state `IDLE`, `cnt=0`, latches 0, `ramstate=FREE` (or `ERROR` if inputs are illegal), `ramload=0`.
- **Latency**: a request first seen in `IDLE` in cycle 0 gives `BUSY` in cycles 1..LAT and `ACCESS` in cycle LAT+1. With `LAT=0`, `ACCESS` is in cycle 1.
- **Back-to-back** requests held continuously: one `ACCESS` every LAT+1 cycles. There is no `FREE` gap; `ACC` goes straight to `BUSY` (or to `ACC` when `LAT=0`).
- **Controller switch**: the controller may change from instruction to data address mid-`WAIT`. This restarts the count; the previous transaction is abandoned with no side effect.
- **Reset mid-transaction**: the transaction is aborted and no write occurs. If reset asserts during `ACC`, the write at that edge is suppressed, because the async reset wins.
- **Address range**: top word `(2^ADDR_BITS-1)` is legal. One past it gives `ERROR`; there is no wrap-around.

## Test plan
- **Reset**, `LAT=2`: hold `nRST=0`, then release with no request → `ramstate=FREE`, `ramload=0` every cycle.
- **Write then read**, `LAT=2`:
  - write `ramaddr=0x40`, `ramstore=0xDEADBEEF` → `BUSY`,`BUSY`,`ACCESS` in cycles 1–3;
  - then read `0x40` → `ACCESS` in cycle 3 of the read with `ramload=0xDEADBEEF`.
- **Restart**, `LAT=2`: read `0x100`, then switch to `0x200` in cycle 1 (`BUSY`) → `ACCESS` 3 cycles after the switch, data from `0x200`; `mem[0x100]` is untouched.
- **Back-to-back**, `LAT=0`: hold a read while stepping the address `0x0`, `0x4`, `0x8` each cycle → `ACCESS` every cycle with matching data.
- **Errors**:
  - `ramREN=ramWEN=1` → `ERROR` that cycle, then `FREE`, memory unchanged;
  - `ramaddr=0x3` → `ERROR`;
  - `ramaddr=4*2^14` with `ADDR_BITS=14` → `ERROR`.
- **Abort**: assert `nRST=0` during the `ACCESS` cycle of a write of `0x12345678` to `0x80` → subsequent read of `0x80` returns the prior value.
